// File: rtl/akarin_pkg.sv
// Shared types for the execute stage.
//   alu_op_e  : operation encoding carried from decode (values 20..31 are undefined, treated as NOP)
//   state_e   : execute-stage control state
//   is_muldiv : op needs the iterative multiply/divide unit
//   is_div    : op is one of DIV/DIVU/REM/REMU
package akarin_pkg;

    typedef enum logic [4:0] {
        OpNop    = 5'd0,
        OpAdd    = 5'd1,
        OpSub    = 5'd2,
        OpAnd    = 5'd3,
        OpOr     = 5'd4,
        OpXor    = 5'd5,
        OpSlt    = 5'd6,
        OpSltu   = 5'd7,
        OpSll    = 5'd8,
        OpSrl    = 5'd9,
        OpSra    = 5'd10,
        OpLui    = 5'd11,
        OpMul    = 5'd12,
        OpMulh   = 5'd13,
        OpMulhsu = 5'd14,
        OpMulhu  = 5'd15,
        OpDiv    = 5'd16,
        OpDivu   = 5'd17,
        OpRem    = 5'd18,
        OpRemu   = 5'd19
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2
    } state_e;

    function automatic logic is_muldiv(input alu_op_e op);
        return (op >= OpMul) && (op <= OpRemu);
    endfunction

    function automatic logic is_div(input alu_op_e op);
        return (op >= OpDiv) && (op <= OpRemu);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M-style multiply/divide datapath.
//   clk, rst   : clock, synchronous active-low reset
//   kill       : abort the current operation (counter cleared)
//   start      : capture op and operands this cycle
//   step       : perform one iteration this cycle
//   op         : MUL*/DIV*/REM* operation
//   src1, src2 : operands
//   done       : this step is the final iteration; result is valid this cycle
//   result     : final, sign-corrected result (meaningful only while done)
// Multiply retires MUL_BITS multiplier bits per step (XLEN/MUL_BITS steps); divide is restoring
// radix-2 (XLEN steps). Both work on magnitudes; signs are applied on the final step.
module muldiv_iter
    import akarin_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill,
    input  logic            start,
    input  logic            step,
    input  alu_op_e         op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] MulLast = CntW'(XLEN / MUL_BITS - 1);
    localparam logic [CntW-1:0] DivLast = CntW'(XLEN - 1);

    alu_op_e           op_q, op_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    // Multiply: {partial high, remaining multiplier}. Divide: {remainder, quotient/dividend}.
    logic [2*XLEN-1:0] acc_q, acc_d;
    // Multiplicand (multiply) or divisor (divide) magnitude.
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   src1_q, src1_d;
    logic              neg_q, neg_d;
    logic              neg_rem_q, neg_rem_d;
    logic              div0_q, div0_d;

    logic                 s1_neg, s2_neg;
    logic [XLEN-1:0]      mag1, mag2;
    logic [MUL_BITS-1:0]  digit;
    logic [XLEN+MUL_BITS-1:0] partial, upper;
    logic [2*XLEN-1:0]    mul_acc, div_acc, acc_next, prod_s;
    logic [XLEN:0]        rem_sh, trial;
    logic                 q_bit;
    logic [XLEN-1:0]      quo, rem;

    assign done = step & (cnt_q == (is_div(op_q) ? DivLast : MulLast));

    // Operand magnitudes at start
    always_comb begin
        s1_neg = src1[XLEN-1] & (op inside {OpMulh, OpMulhsu, OpDiv, OpRem});
        s2_neg = src2[XLEN-1] & (op inside {OpMulh, OpDiv, OpRem});
        mag1   = s1_neg ? -src1 : src1;
        mag2   = s2_neg ? -src2 : src2;
    end

    // One iteration of either algorithm, plus the final result from the post-step accumulator
    always_comb begin
        digit   = acc_q[MUL_BITS-1:0];
        partial = {{MUL_BITS{1'b0}}, opnd_q} * {{XLEN{1'b0}}, digit};
        upper   = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]} + partial;
        mul_acc = {upper, acc_q[XLEN-1:MUL_BITS]};

        rem_sh  = acc_q[2*XLEN-1:XLEN-1];
        trial   = rem_sh - {1'b0, opnd_q};
        q_bit   = ~trial[XLEN];
        div_acc = {(q_bit ? trial[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], q_bit};

        acc_next = is_div(op_q) ? div_acc : mul_acc;
        prod_s   = neg_q ? -acc_next : acc_next;
        quo      = acc_next[XLEN-1:0];
        rem      = acc_next[2*XLEN-1:XLEN];

        result = '0;
        case (op_q)
            OpMul:                       result = prod_s[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu:   result = prod_s[2*XLEN-1:XLEN];
            OpDiv, OpDivu:               result = div0_q ? '1 : (neg_q ? -quo : quo);
            OpRem, OpRemu:               result = div0_q ? src1_q : (neg_rem_q ? -rem : rem);
            default:                     result = '0;
        endcase
    end

    always_comb begin
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        src1_d    = src1_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        if (kill) begin
            cnt_d = '0;
        end else if (start) begin
            op_d      = op;
            cnt_d     = '0;
            acc_d     = {{XLEN{1'b0}}, (is_div(op) ? mag1 : mag2)};
            opnd_d    = is_div(op) ? mag2 : mag1;
            src1_d    = src1;
            neg_d     = s1_neg ^ s2_neg;
            neg_rem_d = s1_neg;
            div0_d    = (src2 == '0);
        end else if (step) begin
            acc_d = acc_next;
            cnt_d = done ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q      <= OpNop;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            src1_q    <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            src1_q    <= src1_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
        end
    end

endmodule

// File: rtl/exec_muldiv_stage.sv
// Execute stage: one registered result slot with valid/ready on both sides.
//   clk, rst            : clock, synchronous active-low reset
//   flush               : abort in-flight op, empty the result slot
//   in_valid/in_ready   : op handshake from decode
//   in_op, in_src1/2    : operation and operands
//   in_dest, in_pc      : destination register and PC, carried to the result
//   out_valid/out_ready : result handshake to memory stage
//   out_res/dest/pc     : result slot contents
//   busy                : multi-cycle multiply/divide in progress
// Single-cycle ALU ops load the slot on accept; MUL*/DIV*/REM* run in muldiv_iter and load the
// slot on their last iteration.
module exec_muldiv_stage
    import akarin_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned MUL_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  alu_op_e           in_op,
    input  logic [XLEN-1:0]   in_src1,
    input  logic [XLEN-1:0]   in_src2,
    input  logic [REG_AW-1:0] in_dest,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_res,
    output logic [REG_AW-1:0] out_dest,
    output logic [XLEN-1:0]   out_pc,
    output logic              busy
);

    localparam int unsigned ShW = $clog2(XLEN);

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_res_q, out_res_d;
    logic [REG_AW-1:0] out_dest_q, out_dest_d;
    logic [XLEN-1:0]   out_pc_q, out_pc_d;
    // Destination/PC of the multi-cycle op, held until it completes
    logic [REG_AW-1:0] md_dest_q, md_dest_d;
    logic [XLEN-1:0]   md_pc_q, md_pc_d;

    logic              accept, md_start, md_done, alu_nop;
    logic [XLEN-1:0]   md_result, alu_res;
    logic [ShW-1:0]    shamt;

    assign in_ready  = rst & ~flush & (state_q == StIdle) & (~out_valid_q | out_ready);
    assign accept    = in_valid & in_ready;
    assign md_start  = accept & is_muldiv(in_op);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign out_dest  = out_dest_q;
    assign out_pc    = out_pc_q;

    muldiv_iter #(
        .XLEN     (XLEN),
        .MUL_BITS (MUL_BITS)
    ) u_muldiv_iter (
        .clk    (clk),
        .rst    (rst),
        .kill   (flush),
        .start  (md_start),
        .step   (busy),
        .op     (in_op),
        .src1   (in_src1),
        .src2   (in_src2),
        .done   (md_done),
        .result (md_result)
    );

    // Single-cycle ALU; undefined encodings fall into the NOP path
    always_comb begin
        alu_res = '0;
        alu_nop = 1'b0;
        shamt   = in_src2[ShW-1:0];
        case (in_op)
            OpAdd:  alu_res = in_src1 + in_src2;
            OpSub:  alu_res = in_src1 - in_src2;
            OpAnd:  alu_res = in_src1 & in_src2;
            OpOr:   alu_res = in_src1 | in_src2;
            OpXor:  alu_res = in_src1 ^ in_src2;
            OpSlt:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in_src1) < $signed(in_src2))};
            OpSltu: alu_res = {{(XLEN-1){1'b0}}, (in_src1 < in_src2)};
            OpSll:  alu_res = in_src1 << shamt;
            OpSrl:  alu_res = in_src1 >> shamt;
            OpSra:  alu_res = $signed(in_src1) >>> shamt;
            OpLui:  alu_res = in_src2;
            OpMul, OpMulh, OpMulhsu, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu: alu_res = '0;
            default: alu_nop = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_dest_d  = out_dest_q;
        out_pc_d    = out_pc_q;
        md_dest_d   = md_dest_q;
        md_pc_d     = md_pc_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_muldiv(in_op)) begin
                        state_d   = is_div(in_op) ? StDiv : StMul;
                        md_dest_d = in_dest;
                        md_pc_d   = in_pc;
                    end else begin
                        out_valid_d = 1'b1;
                        out_res_d   = alu_res;
                        out_dest_d  = alu_nop ? '0 : in_dest;
                        out_pc_d    = in_pc;
                    end
                end
            end
            StMul, StDiv: begin
                // Slot is necessarily empty here: the op was accepted only with the slot free
                // or draining, and nothing else loads it while busy.
                if (md_done) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b1;
                    out_res_d   = md_result;
                    out_dest_d  = md_dest_q;
                    out_pc_d    = md_pc_q;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_dest_q  <= '0;
            out_pc_q    <= '0;
            md_dest_q   <= '0;
            md_pc_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_dest_q  <= out_dest_d;
            out_pc_q    <= out_pc_d;
            md_dest_q   <= md_dest_d;
            md_pc_q     <= md_pc_d;
        end
    end

endmodule
